axis_uart_tx_framed: RTL and testbench
======================================

# axis_uart_tx_framed

Parametrised AXI-Stream-to-UART transmitter with an internal {last,data} FIFO. Each data word can be configured for width, parity mode, stop-bit count and an inter-packet idle gap inserted after every beat flagged with `s_axis_last`. It sits between an AXI-Stream packet source and the device TX pin. It exposes FIFO occupancy and a busy flag for flow monitoring.

## Interface
- `WIDTH`, 8: data bits per UART character; legal range 5..9.
- `DEPTH`, 8: FIFO entries; must be a power of 2, at least 2.
- `CLK_RATE`, 50000000: clock frequency in Hz.
- `BAUD`, 115200: line rate; the bit period is DIV = CLK_RATE/BAUD clocks, truncated; DIV must be at least 2.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: 1 or 2.
- `GAP_BITS`, 0: idle bit-times inserted after the stop bit(s) of a word that has its last flag set; range 0..255.

Ports:
- `clk` in 1: the single clock; all logic is on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `s_axis_data` in WIDTH: data beat.
- `s_axis_valid` in 1: the beat is valid.
- `s_axis_last` in 1: the beat ends a packet.
- `s_axis_ready` out 1: the FIFO can accept a beat.
- `uart_tx` out 1: serial line, idles high.
- `tx_busy` out 1: the FSM is not in IDLE.
- `fifo_level` out $clog2(DEPTH)+1: current FIFO occupancy, 0..DEPTH.

## Operation
- **Write side:** a beat is accepted on an edge where `s_axis_valid && s_axis_ready`; it stores {last,data}.
  - `s_axis_ready = !rst && (fifo_level != DEPTH)`; this is combinational from the registered count.
  - When the FIFO is full there is no write-through, even if a pop happens in the same cycle.
- **Simultaneous push and pop:** `fifo_level` is unchanged and both pointers advance; pointers wrap modulo DEPTH.
- **FSM states:** IDLE, START, DATA, PARITY, STOP, GAP.
- **IDLE:**
  - `uart_tx` = 1.
  - If the FIFO is non-empty: pop the entry, load the shift register and the last flag, set the bit counter to 0, and go to START.
- **START:** `uart_tx` = 0 for DIV clocks, then go to DATA.
- **DATA:** shift WIDTH bits LSB-first, DIV clocks each.
  - Then go to PARITY if PARITY != 0, otherwise go to STOP.
- **PARITY:** drive the XOR of the data bits (even), or its inverse (odd), for DIV clocks.
- **STOP:** `uart_tx` = 1 for STOP_BITS*DIV clocks.
  - Then go to GAP if the last flag is set and GAP_BITS > 0, otherwise go to IDLE.
- **GAP:** `uart_tx` = 1 for GAP_BITS*DIV clocks, then go to IDLE.
- **Bit timer:** counts 0..DIV-1; its width is $clog2(DIV). A state or bit advances on the cycle the counter equals DIV-1.
- **Pop rule:** a pop occurs only in IDLE, so exactly one IDLE clock separates consecutive characters.
- **`tx_busy`:** equals (state != IDLE); it is registered with the state.

## Timing
- **Reset values:**
  - `uart_tx` = 1, `tx_busy` = 0, `fifo_level` = 0, `s_axis_ready` = 0 while `rst` is high.
  - The state is IDLE and the FIFO is flushed.
- **Reset mid-frame:** at the next edge `uart_tx` returns to 1, all queued data is discarded, and no partial frame resumes.
- **Latency (empty FIFO):** a beat accepted at edge E makes `fifo_level` = 1 after E, is popped at E+1, and drives `uart_tx` low after E+2.
- **Character duration:** (1 + WIDTH + (PARITY != 0) + STOP_BITS)*DIV clocks, plus 1 IDLE clock.
  - With GAP, add GAP_BITS*DIV clocks after a last-flagged word.
- **Line stability:** `uart_tx` is a registered output and is glitch-free; it changes only at bit boundaries.
- **Backpressure:** the source may hold `s_axis_valid` and the data while `s_axis_ready` is low; no beat is dropped or duplicated.

## Test plan
- **Single 8N1 word:** CLK_RATE=1000000, BAUD=250000 (DIV=4); push 0xA5.
  - Required: `uart_tx` low 4 clocks, then 1,0,1,0,0,1,0,1 at 4 clocks each, then high.
  - `tx_busy` is high for 40 clocks; `fifo_level` returns to 0.
- **Parity and stop bits:** PARITY=2, STOP_BITS=2; push 0xA5.
  - Required: parity bit 0, 2*DIV stop clocks, frame length 48 clocks.
  - With PARITY=1 the parity bit is 1.
- **Back-to-back words:** push 0x01 then 0x80 with `s_axis_last` = 0 and GAP_BITS=3.
  - Required: exactly 1 idle clock between the stop end and the second start; no gap is inserted.
- **Gap insertion:** same words with `s_axis_last` = 1 on 0x01 and GAP_BITS=3.
  - Required: the line is high for 12+1 clocks between the stop end and the next start.
- **Full FIFO:** DEPTH=4; hold `s_axis_valid` for 6 beats 0x10..0x15.
  - Required: `fifo_level` never exceeds 4 and `s_axis_ready` drops at level 4.
  - All 6 characters appear on the line in order with no loss.
- **Reset mid-frame:** assert `rst` for 1 cycle during the DATA bits of 0x3C with 2 more entries queued.
  - Required: `uart_tx` = 1 and `fifo_level` = 0 after the reset edge; no further characters are sent.
  - A new push afterwards transmits normally.

Source files
------------

// File: rtl/axis_uart_tx_framed.sv
// AXI-Stream to UART transmitter with a {last,data} FIFO, optional parity,
// 1/2 stop bits and an idle gap inserted after packet-ending words.
module axis_uart_tx_framed #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned CLK_RATE  = 50000000,
    parameter int unsigned BAUD      = 115200,
    parameter int unsigned PARITY    = 0,
    parameter int unsigned STOP_BITS = 1,
    parameter int unsigned GAP_BITS  = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         s_axis_data,
    input  logic                     s_axis_valid,
    input  logic                     s_axis_last,
    output logic                     s_axis_ready,
    output logic                     uart_tx,
    output logic                     tx_busy,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    localparam int unsigned DIV   = CLK_RATE / BAUD;
    localparam int unsigned CNT_W = $clog2(DIV);
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned LW    = AW + 1;
    localparam int unsigned BW    = 8;

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_GAP
    } state_t;

    typedef struct packed {
        logic             last;
        logic [WIDTH-1:0] data;
    } entry_t;

    entry_t             mem [DEPTH];
    entry_t             rd_entry;
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic               push;
    logic               pop;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   timer;
    logic [BW-1:0]      bit_n;
    logic               tick;
    logic [WIDTH-1:0]   shreg;
    logic               last_q;
    logic               par_q;
    logic               line_c;

    // FIFO: ready comes from the registered count, so a full FIFO never writes through
    assign s_axis_ready = !rst && (fifo_level != LW'(DEPTH));
    assign push         = s_axis_valid && s_axis_ready;
    assign pop          = (state == S_IDLE) && (fifo_level != '0);
    assign rd_entry     = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            fifo_level <= fifo_level + LW'(push) - LW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {s_axis_last, s_axis_data};
    end

    assign tick = (timer == CNT_W'(DIV - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; bit_n counts bit-times spent in the current state
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (fifo_level != '0) state_nxt = S_START;
            S_START:  if (tick) state_nxt = S_DATA;
            S_DATA:   if (tick && bit_n == BW'(WIDTH - 1))
                          state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
            S_PARITY: if (tick) state_nxt = S_STOP;
            S_STOP:   if (tick && bit_n == BW'(STOP_BITS - 1))
                          state_nxt = (last_q && GAP_BITS != 0) ? S_GAP : S_IDLE;
            S_GAP:    if (tick && bit_n == BW'(GAP_BITS - 1)) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Bit timer, bit counter and character shift register
    always_ff @(posedge clk) begin
        if (rst) begin
            timer  <= '0;
            bit_n  <= '0;
            shreg  <= '0;
            last_q <= 1'b0;
            par_q  <= 1'b0;
        end else begin
            if (state == S_IDLE || tick) timer <= '0;
            else                         timer <= timer + CNT_W'(1);

            if (state_nxt != state) bit_n <= '0;
            else if (tick)          bit_n <= bit_n + BW'(1);

            if (pop) begin
                shreg  <= rd_entry.data;
                last_q <= rd_entry.last;
                par_q  <= (PARITY == 1) ? ~^rd_entry.data : ^rd_entry.data;
            end else if (state == S_DATA && tick) begin
                shreg <= shreg >> 1;
            end
        end
    end

    // Output decode for the current state
    always_comb begin
        line_c = 1'b1;
        case (state)
            S_START:  line_c = 1'b0;
            S_DATA:   line_c = shreg[0];
            S_PARITY: line_c = par_q;
            default:  line_c = 1'b1;
        endcase
    end

    // Registered line and busy flag
    always_ff @(posedge clk) begin
        if (rst) begin
            uart_tx <= 1'b1;
            tx_busy <= 1'b0;
        end else begin
            uart_tx <= line_c;
            tx_busy <= (state_nxt != S_IDLE);
        end
    end

endmodule

// File: tb/tb_axis_uart_tx_framed.sv
// Bench for axis_uart_tx_framed: three configurations (8N1+gap, 8E2, 8O2)
// checked every cycle against a frame-level model plus literal waveform checks.
module tb_axis_uart_tx_framed;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] sd;
    logic       sl;
    logic       v    [3];
    logic       tx   [3];
    logic       busy [3];
    logic       rdy  [3];
    logic [2:0] lvl_a;
    logic [3:0] lvl_b;
    logic [3:0] lvl_c;

    always #5 clk = ~clk;

    axis_uart_tx_framed #(.WIDTH(8), .DEPTH(4), .CLK_RATE(1000000), .BAUD(250000),
                          .PARITY(0), .STOP_BITS(1), .GAP_BITS(3)) dut_a (
        .clk(clk), .rst(rst), .s_axis_data(sd), .s_axis_valid(v[0]), .s_axis_last(sl),
        .s_axis_ready(rdy[0]), .uart_tx(tx[0]), .tx_busy(busy[0]), .fifo_level(lvl_a));

    axis_uart_tx_framed #(.WIDTH(8), .DEPTH(8), .CLK_RATE(1000000), .BAUD(250000),
                          .PARITY(2), .STOP_BITS(2), .GAP_BITS(3)) dut_b (
        .clk(clk), .rst(rst), .s_axis_data(sd), .s_axis_valid(v[1]), .s_axis_last(sl),
        .s_axis_ready(rdy[1]), .uart_tx(tx[1]), .tx_busy(busy[1]), .fifo_level(lvl_b));

    axis_uart_tx_framed #(.WIDTH(8), .DEPTH(8), .CLK_RATE(1000000), .BAUD(250000),
                          .PARITY(1), .STOP_BITS(2), .GAP_BITS(0)) dut_c (
        .clk(clk), .rst(rst), .s_axis_data(sd), .s_axis_valid(v[2]), .s_axis_last(sl),
        .s_axis_ready(rdy[2]), .uart_tx(tx[2]), .tx_busy(busy[2]), .fifo_level(lvl_c));

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic chk_en = 1'b0;

    // Model state
    int         m_cnt [3];
    int         m_rd  [3];
    int         m_wr  [3];
    int         m_pos [3];
    int         m_len [3];
    logic       m_act [3];
    logic [8:0] m_cur [3];
    logic [8:0] m_mem [3][8];
    logic       e_tx  [3];
    logic       e_busy[3];

    // Monitors
    logic prev_busy[3];
    int   run[3], last_run[3], rise_prev[3], rise_last[3], nrise[3];
    int   max_lvl_a;
    logic saw_full;
    logic low_en;
    int   low_cnt;

    function automatic int p_par(input int i);
        return (i == 1) ? 2 : (i == 2) ? 1 : 0;
    endfunction
    function automatic int p_stop(input int i);
        return (i == 0) ? 1 : 2;
    endfunction
    function automatic int p_gap(input int i);
        return (i == 2) ? 0 : 3;
    endfunction
    function automatic int p_dep(input int i);
        return (i == 0) ? 4 : 8;
    endfunction

    function automatic logic exp_rdy(input int i);
        return !rst && (m_cnt[i] < p_dep(i));
    endfunction

    function automatic logic [3:0] lvl_of(input int i);
        if (i == 0) return {1'b0, lvl_a};
        if (i == 1) return lvl_b;
        return lvl_c;
    endfunction

    // Line value of bit-time b within a character frame
    function automatic logic frame_bit(input int par, input logic [8:0] d, input int b);
        logic [7:0] x;
        x = d[7:0];
        if (b == 0) return 1'b0;
        if (b <= 8) return x[b-1];
        if (b == 9 && par != 0) return (par == 2) ? ^x : ~^x;
        return 1'b1;
    endfunction

    task automatic model_step();
        logic pu, po;
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                m_cnt[i] = 0; m_rd[i] = 0; m_wr[i] = 0; m_pos[i] = 0; m_len[i] = 0;
                m_act[i] = 1'b0; e_tx[i] = 1'b1; e_busy[i] = 1'b0;
            end else begin
                pu = v[i] && (m_cnt[i] < p_dep(i));
                po = !m_act[i] && (m_cnt[i] != 0);
                if (m_act[i]) begin
                    e_tx[i] = frame_bit(p_par(i), m_cur[i], m_pos[i] / DIV);
                    m_pos[i]++;
                    if (m_pos[i] == m_len[i]) m_act[i] = 1'b0;
                end else begin
                    e_tx[i] = 1'b1;
                end
                if (po) begin
                    m_cur[i] = m_mem[i][m_rd[i]];
                    m_rd[i]  = (m_rd[i] + 1) % p_dep(i);
                    m_act[i] = 1'b1;
                    m_pos[i] = 0;
                    m_len[i] = (1 + 8 + ((p_par(i) != 0) ? 1 : 0) + p_stop(i)) * DIV
                             + (m_cur[i][8] ? p_gap(i) * DIV : 0);
                end
                if (pu) begin
                    m_mem[i][m_wr[i]] = {sl, sd};
                    m_wr[i] = (m_wr[i] + 1) % p_dep(i);
                end
                m_cnt[i] = m_cnt[i] + (pu ? 1 : 0) - (po ? 1 : 0);
                e_busy[i] = m_act[i];
            end
        end
        if (rst) chk_en = 1'b1;
    endtask

    task automatic compare_all();
        logic [6:0] got, want;
        for (int i = 0; i < 3; i++) begin
            got  = {tx[i], busy[i], lvl_of(i), rdy[i]};
            want = {e_tx[i], e_busy[i], 4'(m_cnt[i]), exp_rdy(i)};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL cycle%0d dut%0d: got tx=%b busy=%b lvl=%0d rdy=%b, want tx=%b busy=%b lvl=%0d rdy=%b",
                         cyc, i, got[6], got[5], got[4:1], got[0], want[6], want[5], want[4:1], want[0]);
            end
        end
    endtask

    task automatic monitor();
        for (int i = 0; i < 3; i++) begin
            if (busy[i]) run[i]++;
            if (prev_busy[i] && !busy[i]) begin last_run[i] = run[i]; run[i] = 0; end
            if (!prev_busy[i] && busy[i]) begin
                rise_prev[i] = rise_last[i]; rise_last[i] = cyc; nrise[i]++;
            end
            prev_busy[i] = busy[i];
        end
        if (int'(lvl_a) > max_lvl_a) max_lvl_a = int'(lvl_a);
        if (!rst && !rdy[0]) saw_full = 1'b1;
        if (low_en && !tx[0]) low_cnt++;
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) compare_all();
        monitor();
    end

    task automatic check(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic push(input int id, input logic [7:0] d, input logic l);
        logic ok;
        int   n;
        ok = 1'b0;
        n  = 0;
        v[id] = 1'b1; sd = d; sl = l;
        while (!ok && n < 500) begin
            @(negedge clk);
            ok = exp_rdy(id);
            @(posedge clk);
            #1;
            n++;
        end
        v[id] = 1'b0;
        if (!ok) check("push_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((m_act[0] || m_act[1] || m_act[2] || m_cnt[0] != 0 || m_cnt[1] != 0 ||
                m_cnt[2] != 0) && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 5000) check("idle_timeout", 0, 1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Samples nb bit-times mid-bit, starting at the start bit of a word just accepted
    task automatic sample_frame(input int id, input int nb, output logic [11:0] bits);
        bits = '0;
        repeat (3) @(posedge clk);
        for (int k = 0; k < nb; k++) begin
            @(negedge clk);
            bits[k] = tx[id];
            repeat (4) @(posedge clk);
        end
        #1;
    endtask

    initial begin
        logic [11:0] bits;
        for (int i = 0; i < 3; i++) begin
            v[i] = 1'b0; prev_busy[i] = 1'b0; run[i] = 0; last_run[i] = 0;
            rise_prev[i] = 0; rise_last[i] = 0; nrise[i] = 0;
        end
        max_lvl_a = 0; saw_full = 1'b0; low_en = 1'b0; low_cnt = 0;
        rst = 1'b1; sd = '0; sl = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_tx", int'(tx[0]), 1);
        check("reset_busy", int'(busy[0]), 0);
        check("reset_level", int'(lvl_a), 0);
        check("reset_ready", int'(rdy[0]), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // 8N1 single word
        push(0, 8'hA5, 1'b0);
        sample_frame(0, 10, bits);
        check("a5_8n1_bits", int'(bits[9:0]), 'h34A);
        wait_idle();
        check("a5_8n1_busy_len", last_run[0], 40);
        check("a5_8n1_level_end", int'(lvl_a), 0);

        // Even parity, 2 stop bits
        push(1, 8'hA5, 1'b0);
        sample_frame(1, 12, bits);
        check("a5_8e2_bits", int'(bits), 'hD4A);
        wait_idle();
        check("a5_8e2_busy_len", last_run[1], 48);

        // Odd parity, 2 stop bits, last set with no gap configured
        push(2, 8'hA5, 1'b1);
        sample_frame(2, 12, bits);
        check("a5_8o2_bits", int'(bits), 'hF4A);
        wait_idle();
        check("a5_8o2_busy_len", last_run[2], 48);

        // Back-to-back, no last: one idle clock between characters
        push(0, 8'h01, 1'b0);
        push(0, 8'h80, 1'b0);
        wait_idle();
        check("b2b_start_spacing", rise_last[0] - rise_prev[0], 41);

        // Gap after a last-flagged word
        push(0, 8'h01, 1'b1);
        push(0, 8'h80, 1'b0);
        wait_idle();
        check("gap_start_spacing", rise_last[0] - rise_prev[0], 53);

        // Full FIFO with valid held over six beats
        max_lvl_a = 0; saw_full = 1'b0; nrise[0] = 0;
        for (int k = 0; k < 6; k++) push(0, 8'(8'h10 + k), 1'b0);
        wait_idle();
        check("full_max_level", max_lvl_a, 4);
        check("full_ready_dropped", int'(saw_full), 1);
        check("full_char_count", nrise[0], 6);

        // Reset during DATA of 0x3C with two more entries queued
        push(0, 8'h3C, 1'b0);
        push(0, 8'h01, 1'b0);
        push(0, 8'h02, 1'b0);
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midreset_tx", int'(tx[0]), 1);
        check("midreset_level", int'(lvl_a), 0);
        check("midreset_busy", int'(busy[0]), 0);
        low_cnt = 0; low_en = 1'b1;
        repeat (120) @(posedge clk);
        #1 low_en = 1'b0;
        check("midreset_line_quiet", low_cnt, 0);
        push(0, 8'h55, 1'b1);
        wait_idle();
        check("post_reset_busy_len", last_run[0], 52);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
